rf_dump_reader: RTL

Debug-side reader for the 32×32 register file. On a start request it walks the file's spare asynchronous read port and captures each register. It then delivers each address/data pair as one beat on a valid/ready stream. The stream is consumed by the board debug/display unit or a host serializer. A single-register mode supports peek-by-address.

---
 rtl/rf_dump_reader_if.sv | 27 ++
 rtl/rf_dump_reader.sv | 108 ++++++++++
 2 files changed

// File: rtl/rf_dump_reader_if.sv
// rtl/rf_dump_reader_if.sv - address/data beat stream from the register-file dump reader
interface rf_dump_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output out_valid,
      input  out_ready,
      output out_addr,
      output out_data,
      output out_last
   );

   modport slave (
      input  out_valid,
      output out_ready,
      input  out_addr,
      input  out_data,
      input  out_last
   );
endinterface

// File: rtl/rf_dump_reader.sv
// rtl/rf_dump_reader.sv - walks the register file's spare read port and streams address/data beats
module rf_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              single,
   input  logic [ADDR_W-1:0] idx_in,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_ra,
   input  logic [DATA_W-1:0] rf_rd,
   rf_dump_reader_if.master  out_if
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              single_q, single_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;

   // idx only moves on rising edges, so driving the read port from it keeps
   // the address steady through SEND/DONE/IDLE.
   assign rf_ra           = idx_q;
   assign out_if.out_addr = addr_q;
   assign out_if.out_data = data_q;
   assign out_if.out_last = last_q;

   // State register; reset aborts any dump in progress.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: one READ bubble per beat, DONE lasts a single cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_READ;
         S_READ: state_d = S_SEND;
         S_SEND: if (out_if.out_ready) state_d = last_q ? S_DONE : S_READ;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state only.
   always_comb begin
      busy             = (state_q != S_IDLE);
      done             = (state_q == S_DONE);
      out_if.out_valid = (state_q == S_SEND);
   end

   // Datapath next values: load on start, snapshot in READ, advance on transfer.
   always_comb begin
      idx_d    = idx_q;
      single_d = single_q;
      addr_d   = addr_q;
      data_d   = data_q;
      last_d   = last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d    = single ? idx_in : '0;
               single_d = single;
            end
         end
         S_READ: begin
            addr_d = idx_q;
            data_d = rf_rd;
            last_d = single_q | (idx_q == LAST_IDX);
         end
         S_SEND: begin
            if (out_if.out_ready && !last_q) idx_d = idx_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers; the captured beat is frozen until its transfer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         idx_q    <= '0;
         single_q <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         single_q <= single_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         last_q   <= last_d;
      end
   end

endmodule
